// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ALU-class instructions until both
// source operands are valid, snooping the ALU and LSB result buses, and issues
// the lowest-index ready entry to the ALU through registered outputs.
module alu_reservation_station #(
   parameter int unsigned RS_SIZE = 8,
   parameter int unsigned RS_BIT  = 3,
   parameter int unsigned ROB_BIT = 4,
   parameter int unsigned OP_W    = 6,
   parameter int unsigned DAT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               clr_i,
   input  logic               dsp_en_i,
   input  logic [OP_W-1:0]    dsp_op_i,
   input  logic               dsp_ic_i,
   input  logic [ROB_BIT-1:0] dsp_qd_i,
   input  logic               dsp_rs_rdy_i,
   input  logic [DAT_W-1:0]   dsp_vs_i,
   input  logic [ROB_BIT-1:0] dsp_qs_i,
   input  logic               dsp_rt_rdy_i,
   input  logic [DAT_W-1:0]   dsp_vt_i,
   input  logic [ROB_BIT-1:0] dsp_qt_i,
   input  logic [DAT_W-1:0]   dsp_imm_i,
   input  logic [DAT_W-1:0]   dsp_pc_i,
   output logic               full_o,
   input  logic               cdb_alu_en_i,
   input  logic [ROB_BIT-1:0] cdb_alu_q_i,
   input  logic [DAT_W-1:0]   cdb_alu_v_i,
   input  logic               cdb_lsb_en_i,
   input  logic [ROB_BIT-1:0] cdb_lsb_q_i,
   input  logic [DAT_W-1:0]   cdb_lsb_v_i,
   output logic               alu_en_o,
   output logic [OP_W-1:0]    alu_op_o,
   output logic               alu_ic_o,
   output logic [ROB_BIT-1:0] alu_qd_o,
   output logic [DAT_W-1:0]   alu_vs_o,
   output logic [DAT_W-1:0]   alu_vt_o,
   output logic [DAT_W-1:0]   alu_imm_o,
   output logic [DAT_W-1:0]   alu_pc_o
);

   // Entry storage
   logic [RS_SIZE-1:0] busy;
   logic [RS_SIZE-1:0] e_ic;
   logic [RS_SIZE-1:0] e_rs_rdy;
   logic [RS_SIZE-1:0] e_rt_rdy;
   logic [OP_W-1:0]    e_op  [RS_SIZE];
   logic [ROB_BIT-1:0] e_qd  [RS_SIZE];
   logic [ROB_BIT-1:0] e_qs  [RS_SIZE];
   logic [ROB_BIT-1:0] e_qt  [RS_SIZE];
   logic [DAT_W-1:0]   e_vs  [RS_SIZE];
   logic [DAT_W-1:0]   e_vt  [RS_SIZE];
   logic [DAT_W-1:0]   e_imm [RS_SIZE];
   logic [DAT_W-1:0]   e_pc  [RS_SIZE];

   logic [RS_SIZE-1:0] cand;
   logic               sel_vld;
   logic [RS_BIT-1:0]  sel_idx;
   logic [RS_BIT-1:0]  free_idx;

   logic               d_rs_rdy;
   logic [DAT_W-1:0]   d_vs;
   logic               d_rt_rdy;
   logic [DAT_W-1:0]   d_vt;

   assign full_o  = &busy;
   assign cand    = busy & e_rs_rdy & e_rt_rdy;
   assign sel_vld = |cand;

   // Lowest-index free entry and lowest-index ready entry (scan high to low so the lowest wins)
   always_comb begin
      free_idx = '0;
      sel_idx  = '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
         if (!busy[RS_BIT'(RS_SIZE - 1 - i)]) free_idx = RS_BIT'(RS_SIZE - 1 - i);
         if (cand[RS_BIT'(RS_SIZE - 1 - i)])  sel_idx  = RS_BIT'(RS_SIZE - 1 - i);
      end
   end

   // Dispatch bypass: capture an operand being broadcast in the dispatch cycle
   always_comb begin
      d_rs_rdy = dsp_rs_rdy_i;
      d_vs     = dsp_vs_i;
      d_rt_rdy = dsp_rt_rdy_i;
      d_vt     = dsp_vt_i;
      if (!dsp_rs_rdy_i) begin
         if (cdb_alu_en_i && cdb_alu_q_i == dsp_qs_i) begin
            d_rs_rdy = 1'b1;
            d_vs     = cdb_alu_v_i;
         end else if (cdb_lsb_en_i && cdb_lsb_q_i == dsp_qs_i) begin
            d_rs_rdy = 1'b1;
            d_vs     = cdb_lsb_v_i;
         end
      end
      if (!dsp_rt_rdy_i) begin
         if (cdb_alu_en_i && cdb_alu_q_i == dsp_qt_i) begin
            d_rt_rdy = 1'b1;
            d_vt     = cdb_alu_v_i;
         end else if (cdb_lsb_en_i && cdb_lsb_q_i == dsp_qt_i) begin
            d_rt_rdy = 1'b1;
            d_vt     = cdb_lsb_v_i;
         end
      end
   end

   // Station state: wakeup, issue and dispatch; an issued entry is always ready and a
   // dispatch target is never busy, so the three updates never touch the same field
   always_ff @(posedge clk) begin
      if (rst) begin
         busy      <= '0;
         alu_en_o  <= 1'b0;
         alu_op_o  <= '0;
         alu_ic_o  <= 1'b0;
         alu_qd_o  <= '0;
         alu_vs_o  <= '0;
         alu_vt_o  <= '0;
         alu_imm_o <= '0;
         alu_pc_o  <= '0;
      end else if (en) begin
         if (clr_i) begin
            busy     <= '0;
            alu_en_o <= 1'b0;
         end else begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
               if (busy[RS_BIT'(i)]) begin
                  if (!e_rs_rdy[RS_BIT'(i)]) begin
                     if (cdb_alu_en_i && cdb_alu_q_i == e_qs[RS_BIT'(i)]) begin
                        e_vs[RS_BIT'(i)]     <= cdb_alu_v_i;
                        e_rs_rdy[RS_BIT'(i)] <= 1'b1;
                     end else if (cdb_lsb_en_i && cdb_lsb_q_i == e_qs[RS_BIT'(i)]) begin
                        e_vs[RS_BIT'(i)]     <= cdb_lsb_v_i;
                        e_rs_rdy[RS_BIT'(i)] <= 1'b1;
                     end
                  end
                  if (!e_rt_rdy[RS_BIT'(i)]) begin
                     if (cdb_alu_en_i && cdb_alu_q_i == e_qt[RS_BIT'(i)]) begin
                        e_vt[RS_BIT'(i)]     <= cdb_alu_v_i;
                        e_rt_rdy[RS_BIT'(i)] <= 1'b1;
                     end else if (cdb_lsb_en_i && cdb_lsb_q_i == e_qt[RS_BIT'(i)]) begin
                        e_vt[RS_BIT'(i)]     <= cdb_lsb_v_i;
                        e_rt_rdy[RS_BIT'(i)] <= 1'b1;
                     end
                  end
               end
            end

            if (sel_vld) begin
               alu_en_o        <= 1'b1;
               alu_op_o        <= e_op[sel_idx];
               alu_ic_o        <= e_ic[sel_idx];
               alu_qd_o        <= e_qd[sel_idx];
               alu_vs_o        <= e_vs[sel_idx];
               alu_vt_o        <= e_vt[sel_idx];
               alu_imm_o       <= e_imm[sel_idx];
               alu_pc_o        <= e_pc[sel_idx];
               busy[sel_idx]   <= 1'b0;
            end else begin
               alu_en_o <= 1'b0;
            end

            if (dsp_en_i && !full_o) begin
               busy[free_idx]     <= 1'b1;
               e_op[free_idx]     <= dsp_op_i;
               e_ic[free_idx]     <= dsp_ic_i;
               e_qd[free_idx]     <= dsp_qd_i;
               e_rs_rdy[free_idx] <= d_rs_rdy;
               e_vs[free_idx]     <= d_vs;
               e_qs[free_idx]     <= dsp_qs_i;
               e_rt_rdy[free_idx] <= d_rt_rdy;
               e_vt[free_idx]     <= d_vt;
               e_qt[free_idx]     <= dsp_qt_i;
               e_imm[free_idx]    <= dsp_imm_i;
               e_pc[free_idx]     <= dsp_pc_i;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: a per-cycle vector table for the
// basic issue/wakeup/bypass paths, then hand-written multi-cycle sequences.
module tb_alu_reservation_station;

   logic        clk = 1'b0;
   logic        rst, en, clr_i;
   logic        dsp_en_i, dsp_ic_i, dsp_rs_rdy_i, dsp_rt_rdy_i;
   logic [5:0]  dsp_op_i;
   logic [3:0]  dsp_qd_i, dsp_qs_i, dsp_qt_i;
   logic [31:0] dsp_vs_i, dsp_vt_i, dsp_imm_i, dsp_pc_i;
   logic        full_o;
   logic        cdb_alu_en_i, cdb_lsb_en_i;
   logic [3:0]  cdb_alu_q_i, cdb_lsb_q_i;
   logic [31:0] cdb_alu_v_i, cdb_lsb_v_i;
   logic        alu_en_o, alu_ic_o;
   logic [5:0]  alu_op_o;
   logic [3:0]  alu_qd_o;
   logic [31:0] alu_vs_o, alu_vt_o, alu_imm_o, alu_pc_o;

   int total = 0;
   int bad   = 0;

   alu_reservation_station #(
      .RS_SIZE(8), .RS_BIT(3), .ROB_BIT(4), .OP_W(6), .DAT_W(32)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .clr_i(clr_i),
      .dsp_en_i(dsp_en_i), .dsp_op_i(dsp_op_i), .dsp_ic_i(dsp_ic_i), .dsp_qd_i(dsp_qd_i),
      .dsp_rs_rdy_i(dsp_rs_rdy_i), .dsp_vs_i(dsp_vs_i), .dsp_qs_i(dsp_qs_i),
      .dsp_rt_rdy_i(dsp_rt_rdy_i), .dsp_vt_i(dsp_vt_i), .dsp_qt_i(dsp_qt_i),
      .dsp_imm_i(dsp_imm_i), .dsp_pc_i(dsp_pc_i), .full_o(full_o),
      .cdb_alu_en_i(cdb_alu_en_i), .cdb_alu_q_i(cdb_alu_q_i), .cdb_alu_v_i(cdb_alu_v_i),
      .cdb_lsb_en_i(cdb_lsb_en_i), .cdb_lsb_q_i(cdb_lsb_q_i), .cdb_lsb_v_i(cdb_lsb_v_i),
      .alu_en_o(alu_en_o), .alu_op_o(alu_op_o), .alu_ic_o(alu_ic_o), .alu_qd_o(alu_qd_o),
      .alu_vs_o(alu_vs_o), .alu_vt_o(alu_vt_o), .alu_imm_o(alu_imm_o), .alu_pc_o(alu_pc_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        dsp_en;
      logic [5:0]  op;
      logic        ic;
      logic [3:0]  qd;
      logic        rs_rdy;
      logic [31:0] vs;
      logic [3:0]  qs;
      logic        rt_rdy;
      logic [31:0] vt;
      logic [3:0]  qt;
      logic [31:0] imm;
      logic [31:0] pc;
      logic        a_en;
      logic [3:0]  a_q;
      logic [31:0] a_v;
      logic        l_en;
      logic [3:0]  l_q;
      logic [31:0] l_v;
      logic        x_en;
      logic        x_data;
      logic [5:0]  x_op;
      logic        x_ic;
      logic [3:0]  x_qd;
      logic [31:0] x_vs;
      logic [31:0] x_vt;
      logic [31:0] x_imm;
      logic [31:0] x_pc;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t idle_vec();
      vec_t v;
      v = '{default: '0};
      v.rs_rdy = 1'b1;
      v.rt_rdy = 1'b1;
      return v;
   endfunction

   function automatic vec_t mkd(input logic [5:0] op, input logic ic, input logic [3:0] qd,
                                input logic rs_rdy, input logic [31:0] vs, input logic [3:0] qs,
                                input logic rt_rdy, input logic [31:0] vt, input logic [3:0] qt,
                                input logic [31:0] imm, input logic [31:0] pc);
      vec_t v;
      v = idle_vec();
      v.dsp_en = 1'b1; v.op = op; v.ic = ic; v.qd = qd;
      v.rs_rdy = rs_rdy; v.vs = vs; v.qs = qs;
      v.rt_rdy = rt_rdy; v.vt = vt; v.qt = qt;
      v.imm = imm; v.pc = pc;
      return v;
   endfunction

   function automatic vec_t xp(input vec_t vin, input logic en_exp, input logic [5:0] op,
                               input logic ic, input logic [3:0] qd, input logic [31:0] vs,
                               input logic [31:0] vt, input logic [31:0] imm, input logic [31:0] pc);
      vec_t v;
      v = vin;
      v.x_en = en_exp; v.x_data = 1'b1; v.x_op = op; v.x_ic = ic; v.x_qd = qd;
      v.x_vs = vs; v.x_vt = vt; v.x_imm = imm; v.x_pc = pc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic idle();
      en = 1'b1; clr_i = 1'b0;
      dsp_en_i = 1'b0; dsp_op_i = '0; dsp_ic_i = 1'b0; dsp_qd_i = '0;
      dsp_rs_rdy_i = 1'b1; dsp_vs_i = '0; dsp_qs_i = '0;
      dsp_rt_rdy_i = 1'b1; dsp_vt_i = '0; dsp_qt_i = '0;
      dsp_imm_i = '0; dsp_pc_i = '0;
      cdb_alu_en_i = 1'b0; cdb_alu_q_i = '0; cdb_alu_v_i = '0;
      cdb_lsb_en_i = 1'b0; cdb_lsb_q_i = '0; cdb_lsb_v_i = '0;
   endtask

   task automatic apply(input vec_t v);
      idle();
      dsp_en_i = v.dsp_en; dsp_op_i = v.op; dsp_ic_i = v.ic; dsp_qd_i = v.qd;
      dsp_rs_rdy_i = v.rs_rdy; dsp_vs_i = v.vs; dsp_qs_i = v.qs;
      dsp_rt_rdy_i = v.rt_rdy; dsp_vt_i = v.vt; dsp_qt_i = v.qt;
      dsp_imm_i = v.imm; dsp_pc_i = v.pc;
      cdb_alu_en_i = v.a_en; cdb_alu_q_i = v.a_q; cdb_alu_v_i = v.a_v;
      cdb_lsb_en_i = v.l_en; cdb_lsb_q_i = v.l_q; cdb_lsb_v_i = v.l_v;
   endtask

   task automatic dsp(input logic [5:0] op, input logic [3:0] qd, input logic rs_rdy,
                      input logic [31:0] vs, input logic [3:0] qs, input logic [31:0] vt);
      apply(mkd(op, 1'b0, qd, rs_rdy, vs, qs, 1'b1, vt, 4'd0, 32'd0, 32'd0));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic chk_issue(input string nm, input logic [5:0] op, input logic [3:0] qd,
                            input logic [31:0] vs, input logic [31:0] vt);
      chk({nm, ".en"}, 32'(alu_en_o), 32'd1);
      chk({nm, ".op"}, 32'(alu_op_o), 32'(op));
      chk({nm, ".qd"}, 32'(alu_qd_o), 32'(qd));
      chk({nm, ".vs"}, alu_vs_o, vs);
      chk({nm, ".vt"}, alu_vt_o, vt);
   endtask

   initial begin
      // Table: ADD all-ready, ADDI woken by ALU bus, SUB bypassed from LSB bus,
      // AND woken on both operands by both buses in one cycle.
      vecs[0]  = mkd(6'd1, 1'b0, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 32'd0, 32'h100);
      vecs[1]  = idle_vec();
      vecs[2]  = xp(idle_vec(), 1'b1, 6'd1, 1'b0, 4'd3, 32'd5, 32'd7, 32'd0, 32'h100);
      vecs[3]  = xp(mkd(6'd2, 1'b1, 4'd4, 1'b0, 32'd0, 4'd2, 1'b1, 32'd0, 4'd0, 32'd1, 32'h104),
                    1'b0, 6'd1, 1'b0, 4'd3, 32'd5, 32'd7, 32'd0, 32'h100);
      vecs[4]  = idle_vec();
      vecs[4].a_en = 1'b1; vecs[4].a_q = 4'd2; vecs[4].a_v = 32'h10;
      vecs[5]  = idle_vec();
      vecs[6]  = xp(mkd(6'd3, 1'b0, 4'd6, 1'b0, 32'd0, 4'd5, 1'b1, 32'd3, 4'd0, 32'd0, 32'h108),
                    1'b1, 6'd2, 1'b1, 4'd4, 32'h10, 32'd0, 32'd1, 32'h104);
      vecs[6].l_en = 1'b1; vecs[6].l_q = 4'd5; vecs[6].l_v = 32'hFFFF_FFFF;
      vecs[7]  = idle_vec();
      vecs[8]  = xp(idle_vec(), 1'b1, 6'd3, 1'b0, 4'd6, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'h108);
      vecs[9]  = mkd(6'd4, 1'b0, 4'd7, 1'b0, 32'd0, 4'd1, 1'b0, 32'd0, 4'd2, 32'd0, 32'h10C);
      vecs[10] = idle_vec();
      vecs[10].a_en = 1'b1; vecs[10].a_q = 4'd1; vecs[10].a_v = 32'hA;
      vecs[10].l_en = 1'b1; vecs[10].l_q = 4'd2; vecs[10].l_v = 32'hB;
      vecs[11] = idle_vec();
      vecs[12] = xp(idle_vec(), 1'b1, 6'd4, 1'b0, 4'd7, 32'hA, 32'hB, 32'd0, 32'h10C);
      vecs[13] = idle_vec();

      idle();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("reset.en", 32'(alu_en_o), 32'd0);
      chk("reset.full", 32'(full_o), 32'd0);
      chk("reset.op", 32'(alu_op_o), 32'd0);
      chk("reset.vs", alu_vs_o, 32'd0);

      for (int i = 0; i < 14; i++) begin
         apply(vecs[i]);
         chk($sformatf("vec%0d.en", i), 32'(alu_en_o), 32'(vecs[i].x_en));
         chk($sformatf("vec%0d.full", i), 32'(full_o), 32'd0);
         if (vecs[i].x_data) begin
            chk($sformatf("vec%0d.op", i), 32'(alu_op_o), 32'(vecs[i].x_op));
            chk($sformatf("vec%0d.ic", i), 32'(alu_ic_o), 32'(vecs[i].x_ic));
            chk($sformatf("vec%0d.qd", i), 32'(alu_qd_o), 32'(vecs[i].x_qd));
            chk($sformatf("vec%0d.vs", i), alu_vs_o, vecs[i].x_vs);
            chk($sformatf("vec%0d.vt", i), alu_vt_o, vecs[i].x_vt);
            chk($sformatf("vec%0d.imm", i), alu_imm_o, vecs[i].x_imm);
            chk($sformatf("vec%0d.pc", i), alu_pc_o, vecs[i].x_pc);
         end
         tick();
      end

      // Fill all eight entries waiting on tag 7, drop a ninth, then drain in index order
      for (int i = 0; i < 8; i++) begin
         dsp(6'(16 + i), 4'(i), 1'b0, 32'd0, 4'd7, 32'(i));
         chk($sformatf("fill%0d.full", i), 32'(full_o), 32'd0);
         tick();
      end
      chk("full.set", 32'(full_o), 32'd1);
      dsp(6'd63, 4'd15, 1'b0, 32'd0, 4'd7, 32'd99);
      tick();
      chk("full.hold", 32'(full_o), 32'd1);
      cdb_alu_en_i = 1'b1; cdb_alu_q_i = 4'd7; cdb_alu_v_i = 32'hCAFE;
      chk("drain.pre0", 32'(alu_en_o), 32'd0);
      tick();
      chk("drain.pre1", 32'(alu_en_o), 32'd0);
      chk("drain.full1", 32'(full_o), 32'd1);
      tick();
      for (int i = 0; i < 8; i++) begin
         chk_issue($sformatf("drain%0d", i), 6'(16 + i), 4'(i), 32'hCAFE, 32'(i));
         if (i == 0) chk("drain.full0", 32'(full_o), 32'd0);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("drain.post%0d", i), 32'(alu_en_o), 32'd0);
         tick();
      end

      // Global enable low freezes a ready entry
      dsp(6'd50, 4'd9, 1'b1, 32'd1, 4'd0, 32'd2);
      tick();
      en = 1'b0;
      chk("frz.c1", 32'(alu_en_o), 32'd0);
      tick();
      en = 1'b0;
      chk("frz.c2", 32'(alu_en_o), 32'd0);
      tick();
      chk("frz.c3", 32'(alu_en_o), 32'd0);
      tick();
      chk_issue("frz.c4", 6'd50, 4'd9, 32'd1, 32'd2);
      tick();
      chk("frz.c5", 32'(alu_en_o), 32'd0);

      // Entry 1 woken in the cycle entry 0 is selected: order 0, 1, 2
      dsp(6'd40, 4'd1, 1'b0, 32'd0, 4'd10, 32'd0);
      tick();
      dsp(6'd41, 4'd2, 1'b0, 32'd0, 4'd9, 32'd0);
      tick();
      dsp(6'd42, 4'd3, 1'b0, 32'd0, 4'd10, 32'd0);
      tick();
      cdb_alu_en_i = 1'b1; cdb_alu_q_i = 4'd10; cdb_alu_v_i = 32'h1010;
      tick();
      cdb_alu_en_i = 1'b1; cdb_alu_q_i = 4'd9; cdb_alu_v_i = 32'h99;
      chk("ord.c4", 32'(alu_en_o), 32'd0);
      tick();
      chk_issue("ord.i0", 6'd40, 4'd1, 32'h1010, 32'd0);
      tick();
      chk_issue("ord.i1", 6'd41, 4'd2, 32'h99, 32'd0);
      tick();
      chk_issue("ord.i2", 6'd42, 4'd3, 32'h1010, 32'd0);
      tick();
      chk("ord.end", 32'(alu_en_o), 32'd0);

      // Flush with pending entries; dispatch and CDB in the flush cycle are ignored
      for (int i = 0; i < 3; i++) begin
         dsp(6'(30 + i), 4'(i), 1'b0, 32'd0, 4'(11 + i), 32'd0);
         tick();
      end
      dsp(6'd60, 4'd8, 1'b1, 32'd5, 4'd0, 32'd6);
      clr_i = 1'b1;
      cdb_alu_en_i = 1'b1; cdb_alu_q_i = 4'd11; cdb_alu_v_i = 32'h1;
      tick();
      chk("clr.full", 32'(full_o), 32'd0);
      chk("clr.en0", 32'(alu_en_o), 32'd0);
      cdb_alu_en_i = 1'b1; cdb_alu_q_i = 4'd11; cdb_alu_v_i = 32'h1;
      tick();
      cdb_alu_en_i = 1'b1; cdb_alu_q_i = 4'd12; cdb_alu_v_i = 32'h2;
      cdb_lsb_en_i = 1'b1; cdb_lsb_q_i = 4'd13; cdb_lsb_v_i = 32'h3;
      for (int i = 1; i < 5; i++) begin
         chk($sformatf("clr.en%0d", i), 32'(alu_en_o), 32'd0);
         tick();
      end

      // Same with reset; data outputs also return to zero
      for (int i = 0; i < 3; i++) begin
         dsp(6'(30 + i), 4'(i), 1'b0, 32'd0, 4'(11 + i), 32'd0);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst.full", 32'(full_o), 32'd0);
      chk("rst.en", 32'(alu_en_o), 32'd0);
      chk("rst.op", 32'(alu_op_o), 32'd0);
      chk("rst.ic", 32'(alu_ic_o), 32'd0);
      chk("rst.qd", 32'(alu_qd_o), 32'd0);
      chk("rst.vs", alu_vs_o, 32'd0);
      chk("rst.vt", alu_vt_o, 32'd0);
      chk("rst.imm", alu_imm_o, 32'd0);
      chk("rst.pc", alu_pc_o, 32'd0);
      cdb_alu_en_i = 1'b1; cdb_alu_q_i = 4'd11; cdb_alu_v_i = 32'h1;
      tick();
      cdb_alu_en_i = 1'b1; cdb_alu_q_i = 4'd12; cdb_alu_v_i = 32'h2;
      cdb_lsb_en_i = 1'b1; cdb_lsb_q_i = 4'd13; cdb_lsb_v_i = 32'h3;
      for (int i = 1; i < 5; i++) begin
         chk($sformatf("rst.en%0d", i), 32'(alu_en_o), 32'd0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Reservation station in front of the ALU in the Tomasulo out-of-order core.
- Accepts decoded ALU-class instructions (LUI, AUIPC, JAL, JALR, branches, reg-imm and reg-reg ops) from the dispatcher.
- Holds each instruction until both source operands are available, snooping two CDBs (ALU result bus and load/store result bus) for them.
- Issues one ready instruction per cycle to the ALU through registered outputs.

Parameters:
- RS_SIZE, 8, number of entries (power of two).
- RS_BIT, 3, log2(RS_SIZE).
- ROB_BIT, 4, width of ROB tags.
- OP_W, 6, width of the internal opcode.
- DAT_W, 32, datapath width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  global enable; 0 freezes all state
- clr_i  in  1  flush on branch mispredict
- dsp_en_i  in  1  dispatch valid
- dsp_op_i  in  OP_W  opcode
- dsp_ic_i  in  1  compressed instruction (pc+2 link)
- dsp_qd_i  in  ROB_BIT  destination ROB tag
- dsp_rs_rdy_i  in  1  rs1 value valid
- dsp_vs_i  in  DAT_W  rs1 value
- dsp_qs_i  in  ROB_BIT  rs1 producer tag
- dsp_rt_rdy_i  in  1  rs2 value valid
- dsp_vt_i  in  DAT_W  rs2 value
- dsp_qt_i  in  ROB_BIT  rs2 producer tag
- dsp_imm_i  in  DAT_W  immediate
- dsp_pc_i  in  DAT_W  instruction PC
- full_o  out  1  no free entry
- cdb_alu_en_i  in  1  ALU broadcast valid
- cdb_alu_q_i  in  ROB_BIT  ALU broadcast tag
- cdb_alu_v_i  in  DAT_W  ALU broadcast value
- cdb_lsb_en_i  in  1  LSB broadcast valid
- cdb_lsb_q_i  in  ROB_BIT  LSB broadcast tag
- cdb_lsb_v_i  in  DAT_W  LSB broadcast value
- alu_en_o  out  1  issue valid (one-cycle pulse per instruction)
- alu_op_o  out  OP_W  issued opcode
- alu_ic_o  out  1  issued compressed flag
- alu_qd_o  out  ROB_BIT  issued destination tag
- alu_vs_o  out  DAT_W  issued rs1 value
- alu_vt_o  out  DAT_W  issued rs2 value
- alu_imm_o  out  DAT_W  issued immediate
- alu_pc_o  out  DAT_W  issued PC

Behaviour:
- Entry fields: busy, op, ic, qd, rs_rdy, vs, qs, rt_rdy, vt, qt, imm, pc.
- Reset: all busy=0; alu_en_o=0; all alu_*_o=0; full_o=0.
- Priority order: rst > en=0 (hold everything, outputs included) > clr_i.
- clr_i=1:
  - All busy<=0 and alu_en_o<=0.
  - Dispatch and CDB inputs in that cycle are ignored.
- full_o: combinational, 1 iff all RS_SIZE entries are busy, computed from registered busy bits only.
  - An entry freed by issue this cycle does not count as free until the next cycle.
- Dispatch (dsp_en_i & !full_o):
  - Write into the lowest-index free entry; that entry becomes busy next cycle.
  - dsp_en_i while full_o=1 is a protocol error: the instruction is dropped and state is unchanged.
- Wakeup: each cycle, for every busy entry with rs_rdy=0:
  - If cdb_alu_en_i and cdb_alu_q_i==qs, then vs<=cdb_alu_v_i and rs_rdy<=1.
  - Otherwise the same check against the LSB bus.
  - rt / vt / qt are handled identically.
  - Both buses may wake different operands of the same entry in one cycle.
  - If both buses carry the same tag (illegal), the ALU bus wins.
- Dispatch bypass: a dispatched operand with rdy=0 whose tag matches a valid CDB in the same cycle is written as ready with the CDB value.
- Select:
  - Candidates are busy & rs_rdy & rt_rdy, evaluated on registered state (wakeup is not forwarded into select).
  - Lowest index wins.
  - The chosen entry's fields are registered onto alu_*_o with alu_en_o<=1, and its busy<=0 in the same edge.
  - No candidate: alu_en_o<=0; data outputs hold their previous values.
- Latency:
  - Dispatch of an all-ready instruction in cycle t gives alu_en_o=1 in t+2.
  - A CDB wake in cycle t gives issue visible in t+2.
- Unused operands: the dispatcher marks them rdy=1 (e.g. LUI sources, vt for reg-imm ops); the station does not decode opcodes.
- Throughput: at most one dispatch and one issue per cycle, in any combination, including the same entry index being freed and reused on consecutive cycles.

Test Plan:
- Empty RS; dispatch ADD vs=5, vt=7, qd=3, both ready, at cycle 0 -> alu_en_o=1 at cycle 2 with op=ADD, vs=5, vt=7, qd=3; alu_en_o=0 at cycle 3; full_o stays 0.
- Dispatch ADDI with qs=2, rs_rdy=0, imm=1; cdb_alu_en_i=1, q=2, v=0x10 at cycle 4 -> issue at cycle 6 with vs=0x10; no issue before cycle 6.
- Dispatch SUB with qs=5 not ready while cdb_lsb_en_i=1, q=5, v=0xFFFFFFFF in the same cycle -> entry captured ready; issues 2 cycles later with vs=0xFFFFFFFF.
- Dispatch 8 instructions all waiting on tag 7 -> full_o=1; a 9th dispatch is dropped; broadcast tag 7 -> issues from entries 0..7 on 8 consecutive cycles in index order; full_o=0 the cycle after the first issue; the dropped instruction never appears.
- Ready entries at index 0 and 2 plus a waiting entry at index 1; wake index 1 in the same cycle index 0 issues -> issue order 0, 1, 2 on consecutive cycles.
- 3 pending entries, assert clr_i one cycle -> alu_en_o=0 from the next cycle, full_o=0, a later CDB with their tags issues nothing; repeat with rst instead of clr_i -> same, and all alu_*_o return to 0.
